// File: rtl/trp_pkg.sv
// Shared types for the transposer job scheduler: descriptor layout, mode and
// status encodings, scheduler states.
package trp_pkg;

    localparam int AW   = 16;
    localparam int ADIM = 6;

    localparam logic [1:0] BIT8_MODE  = 2'b01;
    localparam logic [1:0] BIT32_MODE = 2'b10;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BADDESC = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [1:0]                 mode;
        logic                       repack_en;
        logic [AW-1:0]              rreq_num;
        logic [AW-1:0]              raddr_base;
        logic [ADIM-1:0][AW-1:0]    raddr_size;
        logic [ADIM-1:0][AW-1:0]    raddr_stride;
        logic [AW-1:0]              wreq_num;
        logic [AW-1:0]              waddr_base;
        logic [ADIM-1:0][AW-1:0]    waddr_size;
        logic [ADIM-1:0][AW-1:0]    waddr_stride;
        logic [AW-1:0]              packed_dim_size;
        logic [AW-1:0]              unpacked_dim_size;
    } trp_desc_t;

    // A descriptor the transposer cannot run: unknown mode or empty request counts.
    function automatic logic desc_bad(input trp_desc_t d);
        return ((d.mode != BIT8_MODE) && (d.mode != BIT32_MODE)) ||
               (d.rreq_num == '0) || (d.wreq_num == '0);
    endfunction

endpackage

// File: rtl/transposer_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/transposer_sched.sv
// Round-robin job scheduler that loads one descriptor at a time into the
// transposer, launches it and reports a completion record per job.
module transposer_sched
    import trp_pkg::*;
#(
    parameter  int AW      = trp_pkg::AW,
    parameter  int ADIM    = trp_pkg::ADIM,
    parameter  int NREQ    = 2,
    parameter  int TIMEOUT = 65535,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_vld,
    output logic [NREQ-1:0]           req_rdy,
    input  trp_desc_t [NREQ-1:0]      req_desc,
    output logic                      done_vld,
    input  logic                      done_rdy,
    output logic [IW-1:0]             done_id,
    output logic [1:0]                done_status,
    output logic [31:0]               done_cycles,
    output logic                      busy,
    output logic                      init_pulse,
    output logic                      repack_en,
    output logic [1:0]                mode,
    output logic [AW-1:0]             rreq_num,
    output logic [AW-1:0]             raddr_base,
    output logic [ADIM-1:0][AW-1:0]   raddr_size,
    output logic [ADIM-1:0][AW-1:0]   raddr_stride,
    output logic [AW-1:0]             wreq_num,
    output logic [AW-1:0]             waddr_base,
    output logic [ADIM-1:0][AW-1:0]   waddr_size,
    output logic [ADIM-1:0][AW-1:0]   waddr_stride,
    output logic [AW-1:0]             packed_dim_size,
    output logic [AW-1:0]             unpacked_dim_size,
    input  logic                      finish
);

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic [NREQ-1:0] req_rdy_q, req_rdy_d;
    trp_desc_t       cfg_q, cfg_d;
    logic            init_q, init_d;
    logic            busy_q, busy_d;
    logic            done_vld_q, done_vld_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [1:0]      done_status_q, done_status_d;
    logic [31:0]     done_cycles_q, done_cycles_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    trp_desc_t       sel_desc;
    logic            sel_bad;
    logic            timeout_hit;
    logic            done_hs;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_vld),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_desc    = req_desc[gnt_id_q];
    assign sel_bad     = desc_bad(sel_desc);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= 32'(TIMEOUT));
    assign done_hs     = done_vld_q && done_rdy;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (arb_any) state_d = S_GRANT; else state_d = S_IDLE;
            S_GRANT:  if (sel_bad) state_d = S_DONE; else state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN:    if (finish || timeout_hit) state_d = S_DONE; else state_d = S_RUN;
            S_DONE:   if (done_hs) state_d = S_IDLE; else state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; everything visible at the ports is a flop.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        gnt_id_d      = gnt_id_q;
        cfg_d         = cfg_q;
        cnt_d         = cnt_q;
        done_vld_d    = done_vld_q;
        done_id_d     = done_id_q;
        done_status_d = done_status_q;
        done_cycles_d = done_cycles_q;
        req_rdy_d     = '0;
        init_d        = 1'b0;
        busy_d        = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    gnt_id_d  = arb_idx;
                    req_rdy_d = arb_gnt;
                end else begin
                    gnt_id_d = gnt_id_q;
                end
            end
            S_GRANT: begin
                cfg_d    = sel_desc;
                rr_ptr_d = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + IW'(1);
                cnt_d    = 32'd1;
                if (sel_bad) begin
                    done_vld_d    = 1'b1;
                    done_id_d     = gnt_id_q;
                    done_status_d = ST_BADDESC;
                    done_cycles_d = 32'd0;
                end else begin
                    init_d = 1'b1;
                end
            end
            S_LAUNCH: cnt_d = cnt_q + 32'd1;
            S_RUN: begin
                if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1; else cnt_d = cnt_q;
                // finish takes priority over a coincident watchdog expiry
                if (finish || timeout_hit) begin
                    done_vld_d    = 1'b1;
                    done_id_d     = gnt_id_q;
                    done_status_d = finish ? ST_OK : ST_TIMEOUT;
                    done_cycles_d = cnt_q;
                end else begin
                    done_vld_d = 1'b0;
                end
            end
            S_DONE:   if (done_hs) done_vld_d = 1'b0; else done_vld_d = 1'b1;
            default:  done_vld_d = 1'b0;
        endcase
    end

    // Registered outputs, config and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            gnt_id_q      <= '0;
            cfg_q         <= '0;
            cnt_q         <= 32'd0;
            req_rdy_q     <= '0;
            init_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_vld_q    <= 1'b0;
            done_id_q     <= '0;
            done_status_q <= 2'd0;
            done_cycles_q <= 32'd0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            gnt_id_q      <= gnt_id_d;
            cfg_q         <= cfg_d;
            cnt_q         <= cnt_d;
            req_rdy_q     <= req_rdy_d;
            init_q        <= init_d;
            busy_q        <= busy_d;
            done_vld_q    <= done_vld_d;
            done_id_q     <= done_id_d;
            done_status_q <= done_status_d;
            done_cycles_q <= done_cycles_d;
        end
    end

    assign req_rdy           = req_rdy_q;
    assign init_pulse        = init_q;
    assign busy              = busy_q;
    assign done_vld          = done_vld_q;
    assign done_id           = done_id_q;
    assign done_status       = done_status_q;
    assign done_cycles       = done_cycles_q;
    assign mode              = cfg_q.mode;
    assign repack_en         = cfg_q.repack_en;
    assign rreq_num          = cfg_q.rreq_num;
    assign raddr_base        = cfg_q.raddr_base;
    assign raddr_size        = cfg_q.raddr_size;
    assign raddr_stride      = cfg_q.raddr_stride;
    assign wreq_num          = cfg_q.wreq_num;
    assign waddr_base        = cfg_q.waddr_base;
    assign waddr_size        = cfg_q.waddr_size;
    assign waddr_stride      = cfg_q.waddr_stride;
    assign packed_dim_size   = cfg_q.packed_dim_size;
    assign unpacked_dim_size = cfg_q.unpacked_dim_size;

endmodule

// File: tb/tb_transposer_sched.sv
// Directed bench for transposer_sched: expected completions go into a queue,
// a negedge monitor pops and compares whenever a completion is handed over.
module tb_transposer_sched;
    import trp_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             req_vld;
    logic [1:0]             req_rdy;
    trp_desc_t [1:0]        req_desc;
    logic                   done_vld;
    logic                   done_rdy;
    logic [0:0]             done_id;
    logic [1:0]             done_status;
    logic [31:0]            done_cycles;
    logic                   busy;
    logic                   init_pulse;
    logic                   repack_en;
    logic [1:0]             mode;
    logic [15:0]            rreq_num, raddr_base, wreq_num, waddr_base;
    logic [5:0][15:0]       raddr_size, raddr_stride, waddr_size, waddr_stride;
    logic [15:0]            packed_dim_size, unpacked_dim_size;
    logic                   finish;

    typedef struct {
        logic [0:0]  id;
        logic [1:0]  st;
        logic [31:0] cyc;
        bit          chk_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   gnt_log[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_init   = 0;
    int   n0;

    transposer_sched #(.AW(16), .ADIM(6), .NREQ(2), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .req_vld(req_vld), .req_rdy(req_rdy), .req_desc(req_desc),
        .done_vld(done_vld), .done_rdy(done_rdy), .done_id(done_id), .done_status(done_status),
        .done_cycles(done_cycles), .busy(busy), .init_pulse(init_pulse), .repack_en(repack_en),
        .mode(mode), .rreq_num(rreq_num), .raddr_base(raddr_base), .raddr_size(raddr_size),
        .raddr_stride(raddr_stride), .wreq_num(wreq_num), .waddr_base(waddr_base),
        .waddr_size(waddr_size), .waddr_stride(waddr_stride), .packed_dim_size(packed_dim_size),
        .unpacked_dim_size(unpacked_dim_size), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic trp_desc_t mk(input logic [1:0] m, input logic [15:0] rn,
                                     input logic [15:0] wn, input logic [15:0] tag);
        trp_desc_t d;
        d = '0;
        d.mode = m;
        d.repack_en = 1'b1;
        d.rreq_num = rn;
        d.wreq_num = wn;
        d.raddr_base = tag;
        d.waddr_base = tag + 16'h0100;
        d.packed_dim_size = 16'd4;
        d.unpacked_dim_size = 16'd8;
        for (int i = 0; i < 6; i++) begin
            d.raddr_size[i] = 16'(i + 1);
            d.raddr_stride[i] = 16'(2 * i);
        end
        return d;
    endfunction

    task automatic push_exp(input logic [0:0] id, input logic [1:0] st,
                            input logic [31:0] cyc, input bit chk);
        exp_t e;
        e.id = id; e.st = st; e.cyc = cyc; e.chk_cyc = chk;
        exp_q.push_back(e);
    endtask

    // Wait for the handshake of requester id, then withdraw its request.
    task automatic grant_drop(input int id);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (req_rdy[id]) seen = 1'b1;
        end
        if (!seen) check("grant_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_vld[id] = 1'b0;
    endtask

    task automatic wait_init();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (init_pulse) seen = 1'b1;
        end
        if (!seen) check("init_wait", 32'd0, 32'd1);
    endtask

    // Called at the negedge of the init_pulse cycle: finish lands n cycles later.
    task automatic pulse_finish(input int n);
        repeat (n) @(posedge clk);
        #1 finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        if (!seen) check("idle_wait", 32'd0, 32'd1);
    endtask

    // Monitor: grant log, init count and completion scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (init_pulse) n_init++;
            for (int i = 0; i < 2; i++) begin
                if (req_rdy[i]) begin
                    gnt_log.push_back(i);
                    check("rdy_without_vld", 32'(req_vld[i]), 32'd1);
                end
            end
            if (done_vld && done_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_id", 32'(done_id), 32'(mon_e.id));
                    check("done_status", 32'(done_status), 32'(mon_e.st));
                    if (mon_e.chk_cyc) check("done_cycles", done_cycles, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_vld = 2'b00; req_desc = '0; done_rdy = 1'b1; finish = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_vld", 32'(done_vld), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_init", 32'(init_pulse), 32'd0);
        check("rst_done_cycles", done_cycles, 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_rreq_num", 32'(rreq_num), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single BIT8 job from requester 0, finish 20 cycles after init.
        req_desc[0] = mk(BIT8_MODE, 16'd4, 16'd4, 16'h0010);
        push_exp(1'b0, ST_OK, 32'd21, 1'b1);
        req_vld[0] = 1'b1;
        @(negedge clk); check("rdy_latency_early", 32'(req_rdy[0]), 32'd0);
        @(negedge clk); check("rdy_latency", 32'(req_rdy[0]), 32'd1);
        @(posedge clk); #1 req_vld[0] = 1'b0;
        wait_init();
        check("cfg_rreq_num", 32'(rreq_num), 32'd4);
        check("cfg_raddr_base", 32'(raddr_base), 32'h10);
        check("cfg_mode", 32'(mode), 32'(BIT8_MODE));
        pulse_finish(20);
        wait_idle();
        check("t1_init_count", 32'(n_init), 32'd1);

        // Reset in RUN: no completion, outputs back to reset values.
        req_desc[0] = mk(BIT32_MODE, 16'd8, 16'd8, 16'h0020);
        req_vld[0] = 1'b1;
        grant_drop(0);
        wait_init();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_init", 32'(init_pulse), 32'd0);
        check("rr_done_vld", 32'(done_vld), 32'd0);
        check("rr_done_cycles", done_cycles, 32'd0);
        check("rr_mode", 32'(mode), 32'd0);
        check("rr_rreq_num", 32'(rreq_num), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Both requesting for three jobs: order 0,1,0 from a freshly reset pointer.
        gnt_log.delete();
        req_desc[0] = mk(BIT8_MODE, 16'd2, 16'd2, 16'h0030);
        req_desc[1] = mk(BIT32_MODE, 16'd3, 16'd3, 16'h0040);
        push_exp(1'b0, ST_OK, 32'd6, 1'b1);
        push_exp(1'b1, ST_OK, 32'd6, 1'b1);
        push_exp(1'b0, ST_OK, 32'd6, 1'b1);
        req_vld = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_init();
            if (k == 2) req_vld = 2'b00;
            pulse_finish(5);
        end
        wait_idle();
        check("rr_grant_count", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() == 3) begin
            check("rr_grant0", 32'(gnt_log[0]), 32'd0);
            check("rr_grant1", 32'(gnt_log[1]), 32'd1);
            check("rr_grant2", 32'(gnt_log[2]), 32'd0);
        end

        // Bad descriptors: no launch, config still loaded.
        n0 = n_init;
        req_desc[1] = mk(2'b00, 16'd7, 16'd7, 16'h0050);
        push_exp(1'b1, ST_BADDESC, 32'd0, 1'b0);
        req_vld[1] = 1'b1;
        grant_drop(1);
        wait_idle();
        check("bad_mode_cfg_mode", 32'(mode), 32'd0);
        check("bad_mode_cfg_rreq", 32'(rreq_num), 32'd7);
        check("bad_mode_cfg_base", 32'(raddr_base), 32'h50);
        req_desc[0] = mk(BIT32_MODE, 16'd9, 16'd0, 16'h0060);
        push_exp(1'b0, ST_BADDESC, 32'd0, 1'b0);
        req_vld[0] = 1'b1;
        grant_drop(0);
        wait_idle();
        check("bad_wreq_cfg_wreq", 32'(wreq_num), 32'd0);
        check("bad_wreq_cfg_rreq", 32'(rreq_num), 32'd9);
        check("bad_wreq_cfg_mode", 32'(mode), 32'(BIT32_MODE));
        check("bad_no_init", 32'(n_init), 32'(n0));

        // Watchdog expiry, then a normal job relaunches.
        n0 = n_init;
        req_desc[1] = mk(BIT8_MODE, 16'd5, 16'd5, 16'h0070);
        push_exp(1'b1, ST_TIMEOUT, 32'd50, 1'b1);
        req_vld[1] = 1'b1;
        grant_drop(1);
        wait_idle();
        req_desc[0] = mk(BIT8_MODE, 16'd6, 16'd6, 16'h0080);
        push_exp(1'b0, ST_OK, 32'd11, 1'b1);
        req_vld[0] = 1'b1;
        grant_drop(0);
        wait_init();
        pulse_finish(10);
        wait_idle();
        check("to_init_count", 32'(n_init), 32'(n0 + 2));

        // Completion stalled by done_rdy=0 with another requester pending.
        done_rdy = 1'b0;
        req_desc[1] = mk(BIT32_MODE, 16'd4, 16'd4, 16'h0090);
        req_desc[0] = mk(BIT8_MODE, 16'd2, 16'd2, 16'h00A0);
        push_exp(1'b1, ST_OK, 32'd4, 1'b1);
        req_vld[1] = 1'b1;
        grant_drop(1);
        wait_init();
        req_vld[0] = 1'b1;
        pulse_finish(3);
        n0 = n_init;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 finish = (i == 3);
            @(negedge clk);
            check("stall_no_rdy", 32'(req_rdy), 32'd0);
            check("stall_done_vld", 32'(done_vld), 32'd1);
            check("stall_cycles", done_cycles, 32'd4);
        end
        @(posedge clk); #1 finish = 1'b0;
        check("stall_no_init", 32'(n_init), 32'(n0));
        done_rdy = 1'b1;
        push_exp(1'b0, ST_OK, 32'd3, 1'b1);
        grant_drop(0);
        wait_init();
        pulse_finish(2);
        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
